// File: rtl/mem_port_arbiter.sv
// Two-requester data-memory port arbiter: the CPU MEM stage has priority, and the
// debug loader is guaranteed one slot after STARVE_MAX consecutive denials.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_func3,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [2:0]        dbg_func3,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX) + 1;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_DBG = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_rd_valid;
  logic              r_rd_owner;  // 1 = debug owns the outstanding read

  logic w_force;
  logic w_cpu_gnt;
  logic w_dbg_gnt;
  logic w_dbg_denied;

  assign w_force      = (r_state == FORCE_DBG);
  assign w_dbg_gnt    = !reset && dbg_req && (w_force || !cpu_req);
  assign w_cpu_gnt    = !reset && cpu_req && !(w_force && dbg_req);
  assign w_dbg_denied = !reset && dbg_req && !w_dbg_gnt;

  assign dbg_gnt    = w_dbg_gnt;
  assign cpu_stall  = !reset && w_force && dbg_req && cpu_req;
  assign cpu_rvalid = r_rd_valid && !r_rd_owner;
  assign dbg_rvalid = r_rd_valid && r_rd_owner;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = '0;
    if (w_cpu_gnt) begin
      mem_rd    = !cpu_we;
      mem_wr    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_func3 = cpu_func3;
    end else if (w_dbg_gnt) begin
      mem_rd    = !dbg_we;
      mem_wr    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_func3 = dbg_func3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_rd_valid <= mem_rd;
      r_rd_owner <= w_dbg_gnt;

      if (w_dbg_denied) begin
        if (r_starve_cnt != CNT_W'(STARVE_MAX))
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end

      // The forced slot lasts exactly one cycle, whether or not debug still wants it.
      case (r_state)
        NORMAL:
          if (w_dbg_denied && r_starve_cnt == CNT_W'(STARVE_MAX - 1))
            r_state <= FORCE_DBG;
        FORCE_DBG: r_state <= NORMAL;
        default:   r_state <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared against a streak-counting reference model with a shadow memory.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
  logic [2:0] cpu_func3, dbg_func3, mem_func3;
  logic cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_rd, mem_wr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_func3(cpu_func3), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_func3(dbg_func3), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  // Memory device emulation driven by whatever the DUT puts on the port.
  logic [DATA_W-1:0] tb_mem [0:511];
  logic [DATA_W-1:0] shadow [0:511];
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= tb_mem[mem_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  int streak;
  bit force_next, force_now;
  bit pend_valid, pend_owner;
  logic [DATA_W-1:0] pend_data;
  logic exp_cpu_gnt, exp_dbg_gnt, exp_stall, exp_mem_rd, exp_mem_wr;
  logic exp_cpu_rvalid, exp_dbg_rvalid;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_rdata;
  logic [2:0] exp_func3;

  task automatic apply(input logic creq, input logic cwe, input logic [ADDR_W-1:0] caddr,
                       input logic [DATA_W-1:0] cwd, input logic [2:0] cf3,
                       input logic dreq, input logic dwe, input logic [ADDR_W-1:0] daddr,
                       input logic [DATA_W-1:0] dwd, input logic [2:0] df3);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd; cpu_func3 = cf3;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd; dbg_func3 = df3;
    exp_cpu_gnt = 0; exp_dbg_gnt = 0; exp_stall = 0; exp_mem_rd = 0; exp_mem_wr = 0;
    exp_addr = '0; exp_wdata = '0; exp_func3 = '0;
    exp_cpu_rvalid = 0; exp_dbg_rvalid = 0; exp_rdata = pend_data;
    force_now = 0;
    if (!reset) begin
      force_now      = force_next;
      exp_dbg_gnt    = dreq && (force_now || !creq);
      exp_cpu_gnt    = creq && !(force_now && dreq);
      exp_stall      = force_now && dreq && creq;
      exp_cpu_rvalid = pend_valid && !pend_owner;
      exp_dbg_rvalid = pend_valid && pend_owner;
      if (exp_cpu_gnt) begin
        exp_mem_rd = !cwe; exp_mem_wr = cwe; exp_addr = caddr; exp_wdata = cwd; exp_func3 = cf3;
      end else if (exp_dbg_gnt) begin
        exp_mem_rd = !dwe; exp_mem_wr = dwe; exp_addr = daddr; exp_wdata = dwd; exp_func3 = df3;
      end
    end
    #4;
  endtask

  task automatic advance();
    if (reset) begin
      streak = 0; force_next = 0; pend_valid = 0;
    end else begin
      pend_valid = exp_mem_rd;
      pend_owner = exp_dbg_gnt;
      if (exp_mem_rd) pend_data = shadow[exp_addr];
      if (exp_mem_wr) shadow[exp_addr] = exp_wdata;
      if (dbg_req && !exp_dbg_gnt) streak++;
      else streak = 0;
      force_next = !force_now && dbg_req && !exp_dbg_gnt && (streak == STARVE_MAX);
    end
    $display("cyc %0d rst=%0b cpu_gnt=%0b dbg_gnt=%0b stall=%0b rd=%0b wr=%0b addr=%h",
             cyc, reset, exp_cpu_gnt, exp_dbg_gnt, exp_stall, exp_mem_rd, exp_mem_wr, exp_addr);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, '0, '0, 3'd0, 0, 0, '0, '0, 3'd0);
      advance();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(1, 0, 9'h011, 32'h1, 3'd2, 1, 1, 9'h012, 32'h2, 3'd2);
    n_cmp++;
    if ({cpu_stall, dbg_gnt, mem_rd, mem_wr, cpu_rvalid, dbg_rvalid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000",
                         {cpu_stall, dbg_gnt, mem_rd, mem_wr, cpu_rvalid, dbg_rvalid});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_func3} !== '0) begin
      n_fail++; $display("FAIL reset_bus got addr=%h wdata=%h f3=%h exp 0", mem_addr, mem_wdata, mem_func3);
    end
    advance();
    advance();
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_cpu_load();
    apply(1, 0, 9'h010, '0, 3'd2, 0, 0, '0, '0, 3'd0);
    n_cmp++;
    if ({mem_rd, mem_wr, cpu_stall, dbg_gnt} !== 4'b1000 || mem_addr !== 9'h010) begin
      n_fail++; $display("FAIL cpu_load_issue got rd/wr/stall/gnt=%b addr=%h exp 1000 010",
                         {mem_rd, mem_wr, cpu_stall, dbg_gnt}, mem_addr);
    end
    advance();
    apply(0, 0, '0, '0, 3'd0, 0, 0, '0, '0, 3'd0);
    n_cmp++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b10 || cpu_rdata !== shadow[9'h010]) begin
      n_fail++; $display("FAIL cpu_load_return got rv=%b data=%h exp rv=10 data=%h",
                         {cpu_rvalid, dbg_rvalid}, cpu_rdata, shadow[9'h010]);
    end
    advance();
    idle(1);
  endtask

  task automatic test_dbg_write();
    apply(0, 0, '0, '0, 3'd0, 1, 1, 9'h020, 32'hDEADBEEF, 3'd2);
    n_cmp++;
    if ({dbg_gnt, mem_wr, mem_rd} !== 3'b110 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 9'h020) begin
      n_fail++; $display("FAIL dbg_write got gnt/wr/rd=%b wdata=%h addr=%h exp 110 deadbeef 020",
                         {dbg_gnt, mem_wr, mem_rd}, mem_wdata, mem_addr);
    end
    advance();
    apply(0, 0, '0, '0, 3'd0, 0, 0, '0, '0, 3'd0);
    n_cmp++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL dbg_write_norv got rv=%b exp 00", {cpu_rvalid, dbg_rvalid});
    end
    advance();
  endtask

  task automatic test_starvation();
    logic [5:0] gnt_pat;
    logic [5:0] stall_pat;
    gnt_pat = '0; stall_pat = '0;
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 9'h030, '0, 3'd2, 1, 0, 9'h034, '0, 3'd2);
      gnt_pat[i] = dbg_gnt; stall_pat[i] = cpu_stall;
      n_cmp++;
      if (mem_addr !== exp_addr) begin
        n_fail++; $display("FAIL starve_addr cycle=%0d got=%h exp=%h", i + 1, mem_addr, exp_addr);
      end
      advance();
    end
    n_cmp++;
    if (gnt_pat !== 6'b010000 || stall_pat !== 6'b010000) begin
      n_fail++; $display("FAIL starve_pattern got gnt=%b stall=%b exp 010000 010000", gnt_pat, stall_pat);
    end
    idle(2);
  endtask

  task automatic test_withdraw();
    logic seen;
    seen = 0;
    for (int i = 1; i <= 7; i++) begin
      apply(1, 1, 9'h040, 32'h5, 3'd2, (i != 3), 0, 9'h044, '0, 3'd2);
      seen = seen | cpu_stall | dbg_gnt;
      advance();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL withdraw_noforce got stall_or_gnt=%b exp 0", seen);
    end
    idle(2);
  endtask

  task automatic test_alternating();
    for (int i = 0; i < STARVE_MAX; i++) begin
      apply(1, 1, 9'h050, 32'hA5, 3'd2, 1, 0, 9'h004, '0, 3'd2);
      advance();
    end
    apply(1, 0, 9'h008, '0, 3'd2, 1, 0, 9'h004, '0, 3'd2);
    n_cmp++;
    if ({dbg_gnt, cpu_stall, mem_rd} !== 3'b111 || mem_addr !== 9'h004) begin
      n_fail++; $display("FAIL alt_forced got gnt/stall/rd=%b addr=%h exp 111 004",
                         {dbg_gnt, cpu_stall, mem_rd}, mem_addr);
    end
    advance();
    apply(1, 0, 9'h008, '0, 3'd2, 0, 0, '0, '0, 3'd0);
    n_cmp++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b01 || dbg_rdata !== shadow[9'h004] || mem_addr !== 9'h008) begin
      n_fail++; $display("FAIL alt_dbg_return got rv=%b data=%h addr=%h exp 01 %h 008",
                         {cpu_rvalid, dbg_rvalid}, dbg_rdata, mem_addr, shadow[9'h004]);
    end
    advance();
    apply(0, 0, '0, '0, 3'd0, 0, 0, '0, '0, 3'd0);
    n_cmp++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b10 || cpu_rdata !== shadow[9'h008]) begin
      n_fail++; $display("FAIL alt_cpu_return got rv=%b data=%h exp 10 %h",
                         {cpu_rvalid, dbg_rvalid}, cpu_rdata, shadow[9'h008]);
    end
    advance();
  endtask

  task automatic test_reset_mid_read();
    apply(1, 0, 9'h060, '0, 3'd2, 0, 0, '0, '0, 3'd0);
    advance();
    reset = 1'b1;
    apply(1, 0, 9'h061, '0, 3'd2, 1, 0, 9'h062, '0, 3'd2);
    n_cmp++;
    if ({cpu_rvalid, dbg_rvalid, cpu_stall, dbg_gnt, mem_rd, mem_wr} !== 6'b0) begin
      n_fail++; $display("FAIL midread_reset got=%b exp 000000",
                         {cpu_rvalid, dbg_rvalid, cpu_stall, dbg_gnt, mem_rd, mem_wr});
    end
    advance();
    reset = 1'b0;
    apply(0, 0, '0, '0, 3'd0, 0, 0, '0, '0, 3'd0);
    n_cmp++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL midread_release got rv=%b exp 00", {cpu_rvalid, dbg_rvalid});
    end
    advance();
  endtask

  task automatic test_random();
    logic dr, dw;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] dd;
    logic [2:0] df;
    bit cr;
    dr = 0; dw = 0; da = '0; dd = '0; df = '0;
    for (int i = 0; i < 400; i++) begin
      // Debug keeps its request stable until granted, but may withdraw.
      if (!(dr && !exp_dbg_gnt && $urandom_range(7) != 0)) begin
        dr = ($urandom_range(2) != 0); dw = $urandom_range(1) == 1;
        da = ADDR_W'($urandom_range(31)); dd = $urandom; df = 3'($urandom_range(7));
      end
      cr = ($urandom_range(9) < 7);
      apply(cr, 1'($urandom_range(1)), ADDR_W'($urandom_range(31)), $urandom, 3'($urandom_range(7)),
            dr, dw, da, dd, df);
      n_cmp++;
      if ({cpu_stall, dbg_gnt, mem_rd, mem_wr, cpu_rvalid, dbg_rvalid} !==
          {exp_stall, exp_dbg_gnt, exp_mem_rd, exp_mem_wr, exp_cpu_rvalid, exp_dbg_rvalid}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc,
          {cpu_stall, dbg_gnt, mem_rd, mem_wr, cpu_rvalid, dbg_rvalid},
          {exp_stall, exp_dbg_gnt, exp_mem_rd, exp_mem_wr, exp_cpu_rvalid, exp_dbg_rvalid});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata, mem_func3} !== {exp_addr, exp_wdata, exp_func3}) begin
        n_fail++; $display("FAIL rnd_bus cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
          mem_addr, mem_wdata, mem_func3, exp_addr, exp_wdata, exp_func3);
      end
      if (exp_cpu_rvalid || exp_dbg_rvalid) begin
        n_cmp++;
        if ((exp_cpu_rvalid ? cpu_rdata : dbg_rdata) !== exp_rdata) begin
          n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc,
            exp_cpu_rvalid ? cpu_rdata : dbg_rdata, exp_rdata);
        end
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      tb_mem[i] = $urandom;
      shadow[i] = tb_mem[i];
    end
    streak = 0; force_next = 0; force_now = 0; pend_valid = 0; pend_owner = 0; pend_data = '0;
    exp_dbg_gnt = 0;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_func3 = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_func3 = '0;
    @(posedge clk); #1;
    test_reset();
    test_cpu_load();
    test_dbg_write();
    test_starvation();
    test_withdraw();
    test_alternating();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, data memory byte address width; DATA_W, default 32, data width; STARVE_MAX, default 4, the number of consecutive denied debug cycles before a forced debug slot.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- cpu_req  in  1  MEM-stage access request (MemRead|MemWrite)
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  address
- cpu_wdata  in  DATA_W  store data
- cpu_func3  in  3  access size/sign
- cpu_stall  out  1  MEM stage must hold; pipeline freezes
- cpu_rvalid  out  1  load data valid
- cpu_rdata  out  DATA_W  load data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_func3  in  1/1/ADDR_W/DATA_W/3  debug-loader request, same meanings as the cpu_* fields
- dbg_gnt  out  1  debug access accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_rd, mem_wr  out  1 each  data memory read/write enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_func3  out  3  memory access size
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd

Function
REQ-004 At most one requester SHALL own the memory port per cycle; mem_* SHALL be driven combinationally from the granted requester's fields.
REQ-005 With no grant, mem_rd, mem_wr, mem_addr, mem_wdata and mem_func3 SHALL all be 0.
REQ-006 FSM states SHALL be NORMAL and FORCE_DBG.
REQ-007 In NORMAL, cpu_req SHALL win; dbg SHALL be granted only when cpu_req=0 and dbg_req=1.
REQ-008 In FORCE_DBG with dbg_req=1, dbg SHALL be granted, and cpu_stall SHALL equal cpu_req.
REQ-009 In FORCE_DBG with dbg_req=0, cpu SHALL be granted if requesting (no stall).
REQ-010 cpu_stall SHALL be 0 in every cycle other than the case in REQ-008.
REQ-011 starve_cnt behaviour:
- width is clog2(STARVE_MAX)+1
- increments in any cycle with dbg_req=1 and dbg_gnt=0
- clears to 0 when dbg_gnt=1 or dbg_req=0
- saturates at STARVE_MAX
REQ-012 NORMAL SHALL go to FORCE_DBG when dbg_req=1, dbg_gnt=0 and starve_cnt=STARVE_MAX-1 (i.e. the STARVE_MAX-th consecutive denial).
REQ-013 FORCE_DBG SHALL return to NORMAL after exactly one cycle, unconditionally.
REQ-014 The debug handshake SHALL follow these rules:
- dbg holds dbg_req and its fields stable until it samples dbg_gnt=1
- the transfer completes in the grant cycle
- dbg may drop dbg_req at any time before the grant
REQ-015 Read return SHALL be one cycle after the read grant:
- a 1-bit owner register and a valid flag are captured on every mem_rd
- the next cycle asserts cpu_rvalid or dbg_rvalid (owner only) for exactly one cycle
- cpu_rdata and dbg_rdata both mirror mem_rdata, qualified by their rvalid
REQ-016 Writes SHALL produce no rvalid.
REQ-017 A stalled cpu request SHALL be granted in the following cycle (NORMAL) if still asserted.
REQ-018 Back-to-back grants to alternating owners SHALL return read data to the correct owner every cycle.

Reset
REQ-019 While reset is asserted, the block SHALL hold:
- state=NORMAL and starve_cnt=0
- owner register and valid flag = 0
- cpu_rvalid=0, dbg_rvalid=0
- cpu_stall=0 and dbg_gnt=0, overriding the request inputs
- mem_rd=0 and mem_wr=0
REQ-020 A transfer in flight when reset asserts SHALL be dropped: no rvalid after reset releases.
REQ-021 After reset releases, the first clk edge SHALL arbitrate normally.

Verification
REQ-022 cpu load only: cpu_req=1, cpu_we=0, addr=0x010 -> that cycle mem_rd=1, mem_addr=0x010, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata, dbg_rvalid=0.
REQ-023 Idle cpu: cpu_req=0, dbg_req=1, dbg_we=1, addr=0x020, wdata=0xDEADBEEF -> dbg_gnt=1 that cycle, mem_wr=1, mem_wdata=0xDEADBEEF; no rvalid afterwards.
REQ-024 Starvation (STARVE_MAX=4): cpu_req=1 and dbg_req=1 held continuously ->
- cycles 1-4: cpu granted
- cycle 5 (FORCE_DBG): dbg_gnt=1, cpu_stall=1
- cycle 6: NORMAL, cpu granted
REQ-025 dbg_req withdrawn at cycle 3 of REQ-024 -> starve_cnt=0, no FORCE_DBG, cpu_stall never asserted.
REQ-026 Alternating owners: cycle 1 forced-dbg read of 0x004, cycle 2 cpu read of 0x008 -> cycle 2 dbg_rvalid=1 only; cycle 3 cpu_rvalid=1 only.
REQ-027 Reset mid-read: reset asserted in the cycle after a cpu read grant -> cpu_rvalid=0 during reset and after release; outputs at the REQ-019 values.
